// File: rtl/findmax_pkg.sv
// findmax_pkg: shared FSM state type and default widths for the findMax datapath
package findmax_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_ADDR_W  = 8;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 3;
endpackage

// File: rtl/max_compare.sv
// max_compare: strict greater-than of two data words; signed when MAXFIND_SIGNED_EN is defined
module max_compare
  import findmax_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_greater
);
`ifdef MAXFIND_SIGNED_EN
  assign o_greater = $signed(i_a) > $signed(i_b);
`else
  assign o_greater = i_a > i_b;
`endif
endmodule

// File: rtl/max_tracker.sv
// max_tracker: streaming max finder pairing counter addresses with delayed memory data
// Build option MAXFIND_SIGNED_EN selects a signed compare inside max_compare.
module max_tracker
  import findmax_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] addrIn,
  input  logic              cntDone,
  input  logic [DATA_W-1:0] dataIn,
  output logic              busy,
  output logic              valid,
  output logic              empty,
  output logic [DATA_W-1:0] maxVal,
  output logic [ADDR_W-1:0] maxAddr
);
  state_t            r_state, w_next;
  logic [1:0]        r_cnt;
  logic              r_have, r_acc, r_empty;
  logic [DATA_W-1:0] r_max;
  logic [ADDR_W-1:0] r_addr;
  logic              w_start, w_acc, w_ev, w_gt;
  logic [ADDR_W-1:0] w_etag;
  assign w_start = start && (r_state == IDLE || r_state == DONE);
  assign w_acc   = r_state == RUN && !cntDone;
  // The tag leaves the line in the cycle its data is on dataIn; with one cycle of latency that is the issue cycle itself.
  if (MEM_LAT == 1) begin : g_direct
    assign w_ev   = w_acc;
    assign w_etag = addrIn;
  end else begin : g_line
    logic [MEM_LAT-2:0] r_v;
    logic [ADDR_W-1:0]  r_tag [MEM_LAT-1];
    always_ff @(posedge clk) begin
      if (!reset || w_start) r_v <= '0;
      else begin
        r_v[0] <= w_acc;
        for (int i = 1; i < MEM_LAT - 1; i++) r_v[i] <= r_v[i-1];
      end
      r_tag[0] <= addrIn;
      for (int i = 1; i < MEM_LAT - 1; i++) r_tag[i] <= r_tag[i-1];
    end
    assign w_ev   = r_v[MEM_LAT-2];
    assign w_etag = r_tag[MEM_LAT-2];
  end
  max_compare #(.DATA_W(DATA_W)) u_cmp (
    .i_a      (dataIn),
    .i_b      (r_max),
    .o_greater(w_gt)
  );
  always_comb begin
    w_next = w_start ? RUN
           : r_state == RUN   ? (cntDone ? (MEM_LAT > 1 ? DRAIN : DONE) : RUN)
           : r_state == DRAIN ? (r_cnt == 2'd0 ? DONE : DRAIN)
           : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_have  <= 1'b0;
      r_acc   <= 1'b0;
      r_empty <= 1'b0;
      r_max   <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == DRAIN ? r_cnt - 2'd1 : 2'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);
      if (w_start) begin
        r_have  <= 1'b0;
        r_acc   <= 1'b0;
        r_empty <= 1'b0;
        r_max   <= '0;
        r_addr  <= '0;
      end else begin
        if (w_acc) r_acc <= 1'b1;
        if (w_ev && (!r_have || w_gt)) begin
          r_max  <= dataIn;
          r_addr <= w_etag;
          r_have <= 1'b1;
        end
        if (w_next == DONE) r_empty <= !r_acc;
      end
    end
  end
  assign busy    = r_state == RUN || r_state == DRAIN;
  assign valid   = r_state == DONE;
  assign empty   = r_empty;
  assign maxVal  = r_max;
  assign maxAddr = r_addr;
endmodule

// File: tb/tb_max_tracker.sv
// tb_max_tracker: scoreboard bench driving one MEM_LAT=1 and one MEM_LAT=3 tracker
module tb_max_tracker;
  typedef struct {
    logic [7:0] v;
    logic [7:0] a;
    logic       e;
    int         c;
  } exp_t;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       st [2];
  logic [7:0] ad [2];
  logic       cd [2];
  logic [7:0] din [2];
  logic       b [2];
  logic       v [2];
  logic       e [2];
  logic [7:0] mv [2];
  logic [7:0] ma [2];
  logic [7:0] mem [256];
  logic [7:0] p1, p2;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  exp_t       sb0[$];
  exp_t       sb1[$];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    p1  <= ad[1];
    p2  <= p1;
  end
  assign din[0] = mem[ad[0]];
  assign din[1] = mem[p2];
  max_tracker #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(st[0]), .addrIn(ad[0]), .cntDone(cd[0]), .dataIn(din[0]),
    .busy(b[0]), .valid(v[0]), .empty(e[0]), .maxVal(mv[0]), .maxAddr(ma[0])
  );
  max_tracker #(.DATA_W(8), .ADDR_W(8), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .reset(rst_n), .start(st[1]), .addrIn(ad[1]), .cntDone(cd[1]), .dataIn(din[1]),
    .busy(b[1]), .valid(v[1]), .empty(e[1]), .maxVal(mv[1]), .maxAddr(ma[1])
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic bit gt(input logic [7:0] a, input logic [7:0] c);
`ifdef MAXFIND_SIGNED_EN
    return $signed(a) > $signed(c);
`else
    return a > c;
`endif
  endfunction
  function automatic exp_t model(input logic [7:0] base, input int n, input int c);
    exp_t       x;
    logic [7:0] a;
    x.v = 8'h00;
    x.a = 8'h00;
    x.e = (n == 0);
    x.c = c;
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      if (i == 0 || gt(mem[a], x.v)) begin
        x.v = mem[a];
        x.a = a;
      end
    end
    return x;
  endfunction
  task automatic cmp_res(input int i, input exp_t x);
    chk($sformatf("maxVal%0d", i), mv[i], x.v);
    chk($sformatf("maxAddr%0d", i), ma[i], x.a);
    chk($sformatf("empty%0d", i), e[i], x.e);
    chk($sformatf("valid_cycle%0d", i), cyc, x.c);
  endtask
  always @(negedge clk) begin
    if (v[0]) begin
      chk("valid0_expected", 32'(sb0.size() > 0), 1);
      if (sb0.size() > 0) cmp_res(0, sb0.pop_front());
    end
    if (v[1]) begin
      chk("valid1_expected", 32'(sb1.size() > 0), 1);
      if (sb1.size() > 0) cmp_res(1, sb1.pop_front());
    end
  end
  task automatic search(input int idx, input logic [7:0] base, input int n, input bit mid, input bit pre);
    int ml;
    ml = idx == 0 ? 1 : 3;
    if (!pre) begin
      @(posedge clk); #1;
      st[idx] = 1'b1;
    end
    @(posedge clk); #1;
    st[idx] = 1'b0;
    chk("busy_run", b[idx], 1);
    for (int i = 0; i < n; i++) begin
      ad[idx] = base + 8'(i);
      st[idx] = mid && i == 1;
      @(posedge clk); #1;
    end
    st[idx] = 1'b0;
    cd[idx] = 1'b1;
    if (idx == 0) sb0.push_back(model(base, n, cyc + ml));
    else sb1.push_back(model(base, n, cyc + ml));
    @(posedge clk); #1;
    cd[idx] = 1'b0;
    ad[idx] = 8'h00;
    for (int j = 1; j < ml; j++) begin
      chk("busy_drain", b[idx], 1);
      chk("valid_drain", v[idx], 0);
      @(posedge clk); #1;
    end
    chk("busy_done", b[idx], 0);
  endtask
  task automatic wait_idle(input int idx);
    int left;
    left = idx == 0 ? sb0.size() : sb1.size();
    for (int k = 0; k < 20 && left > 0; k++) begin
      @(posedge clk); #1;
      left = idx == 0 ? sb0.size() : sb1.size();
    end
    chk("result_timeout", left, 0);
  endtask
  task automatic load_t1();
    mem[8] = 8'd3; mem[9] = 8'd9; mem[10] = 8'd4; mem[11] = 8'd9; mem[12] = 8'd1;
  endtask
  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      st[i] = 1'b0;
      ad[i] = 8'h00;
      cd[i] = 1'b0;
    end
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", b[i], 0);
      chk("rst_valid", v[i], 0);
      chk("rst_empty", e[i], 0);
      chk("rst_maxVal", mv[i], 0);
      chk("rst_maxAddr", ma[i], 0);
    end
    rst_n = 1'b1;
    load_t1();
    search(0, 8'd8, 5, 1'b0, 1'b0);
    wait_idle(0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_maxVal", mv[0], 9);
    chk("hold_maxAddr", ma[0], 9);
    search(0, 8'd30, 0, 1'b0, 1'b0);
    wait_idle(0);
    mem[10] = 8'h7F; mem[11] = 8'h80;
    search(0, 8'd10, 2, 1'b0, 1'b0);
    wait_idle(0);
    load_t1();
    @(posedge clk); #1;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    ad[0] = 8'd8;
    @(posedge clk); #1;
    ad[0] = 8'd9;
    @(posedge clk); #1;
    ad[0] = 8'd10;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ad[0] = 8'd0;
    chk("midrst_busy", b[0], 0);
    chk("midrst_valid", v[0], 0);
    chk("midrst_empty", e[0], 0);
    chk("midrst_maxVal", mv[0], 0);
    chk("midrst_maxAddr", ma[0], 0);
    rst_n = 1'b0;
    st[0] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    st[0] = 1'b0;
    chk("rst_over_start_busy", b[0], 0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("idle_no_valid", v[0], 0);
    end
    search(0, 8'd8, 5, 1'b0, 1'b0);
    wait_idle(0);
    search(0, 8'd8, 5, 1'b1, 1'b0);
    mem[40] = 8'd1; mem[41] = 8'd6; mem[42] = 8'd6; mem[43] = 8'd2;
    st[0] = 1'b1;
    search(0, 8'd40, 4, 1'b0, 1'b1);
    wait_idle(0);
    mem[20] = 8'd5; mem[21] = 8'd2; mem[22] = 8'd7;
    search(1, 8'd20, 3, 1'b0, 1'b0);
    wait_idle(1);
    search(1, 8'd30, 0, 1'b0, 1'b0);
    wait_idle(1);
    for (int r = 0; r < 8; r++) begin
      int idx, n;
      idx = r % 2;
      n = $urandom_range(0, 6);
      for (int i = 0; i < 8; i++) mem[64 + i] = 8'($urandom_range(0, 3) * 60);
      search(idx, 8'd64, n, 1'b0, 1'b0);
      wait_idle(idx);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
